// File: rtl/phy_tx_serializer.sv
// Transmit PHY serializer: merges four lanes into a 32-bit frame and shifts it out MSB first.
// After reset it sends TRAIN_FRAMES all-comma frames, then sends data frames back to back.
module phy_tx_serializer #(
  parameter logic [7:0]  COMMA        = 8'hBC,
  parameter int unsigned TRAIN_FRAMES = 2
) (
  input  logic       clk_32f,
  input  logic       rst_L,
  input  logic [7:0] data_in_0,
  input  logic [7:0] data_in_1,
  input  logic [7:0] data_in_2,
  input  logic [7:0] data_in_3,
  input  logic       valid_in_0,
  input  logic       valid_in_1,
  input  logic       valid_in_2,
  input  logic       valid_in_3,
  output logic       load,
  output logic       data_out,
  output logic       frame_start,
  output logic       tx_active
);

  typedef enum logic {
    TRAIN = 1'b0,
    RUN   = 1'b1
  } state_t;

  localparam logic [3:0] LAST_TRAIN = 4'(TRAIN_FRAMES - 1);

  state_t      state, state_next;
  logic [3:0]  train_cnt, train_cnt_next;
  logic [4:0]  cnt;
  logic [31:0] shift_q;
  logic [31:0] frame;
  logic        load_edge;
  logic        end_of_frame;
  logic        next_is_data;

  assign load_edge    = (cnt == 5'd0);
  assign end_of_frame = (cnt == 5'd31);
  assign data_out     = shift_q[31];

  always_ff @(posedge clk_32f) begin
    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    if (!rst_L) begin
      state     <= TRAIN;
      train_cnt <= 4'd0;
    end else begin
      state     <= state_next;
      train_cnt <= train_cnt_next;
    end
  end

  always_comb begin
    // NOTE: defaults assigned first so no path leaves a variable unassigned (no latches).
    state_next     = state;
    train_cnt_next = train_cnt;
    next_is_data   = (state == RUN);
    if (state == TRAIN) begin
      // The frame following the last training frame is the first data frame.
      next_is_data = (train_cnt == LAST_TRAIN);
      if (end_of_frame) begin
        train_cnt_next = train_cnt + 4'd1;
        if (train_cnt == LAST_TRAIN) state_next = RUN;
      end
    end
  end

  // Invalid lanes, and every lane during training, carry the comma byte.
  always_comb begin
    frame = {4{COMMA}};
    if (state == RUN) begin
      frame = {valid_in_0 ? data_in_0 : COMMA,
               valid_in_1 ? data_in_1 : COMMA,
               valid_in_2 ? data_in_2 : COMMA,
               valid_in_3 ? data_in_3 : COMMA};
    end
  end

  always_ff @(posedge clk_32f) begin
    if (!rst_L) begin
      cnt         <= 5'd0;
      shift_q     <= 32'd0;
      load        <= 1'b0;
      frame_start <= 1'b0;
      tx_active   <= 1'b0;
    end else begin
      cnt         <= cnt + 5'd1;
      shift_q     <= load_edge ? frame : {shift_q[30:0], 1'b0};
      frame_start <= load_edge;
      // Announces the loading edge one cycle ahead, only when that frame carries data.
      load        <= end_of_frame && next_is_data;
      tx_active   <= (state == RUN);
    end
  end

endmodule

// File: tb/tb_phy_tx_serializer.sv
// Self-checking bench for phy_tx_serializer: randomized lanes against a frame-level model
// that predicts the serial stream from the cycle index since reset release.
module tb_phy_tx_serializer;

  localparam int          TF        = 2;
  localparam logic [31:0] ALL_COMMA = 32'hBCBCBCBC;

  logic       clk_32f = 1'b0;
  logic       rst_L   = 1'b0;
  logic [7:0] din [4];
  logic       vin [4];
  logic       load, data_out, frame_start, tx_active;

  int total = 0;
  int bad   = 0;

  // Model state: t is the cycle index since reset release (-1 while in reset).
  int          t = -1;
  logic [31:0] cur_frame = '0;
  logic        exp_data, exp_fs, exp_ta, exp_load;

  always #5 clk_32f = ~clk_32f;

  phy_tx_serializer #(.COMMA(8'hBC), .TRAIN_FRAMES(TF)) dut (
    .clk_32f    (clk_32f),
    .rst_L      (rst_L),
    .data_in_0  (din[0]),
    .data_in_1  (din[1]),
    .data_in_2  (din[2]),
    .data_in_3  (din[3]),
    .valid_in_0 (vin[0]),
    .valid_in_1 (vin[1]),
    .valid_in_2 (vin[2]),
    .valid_in_3 (vin[3]),
    .load       (load),
    .data_out   (data_out),
    .frame_start(frame_start),
    .tx_active  (tx_active)
  );

  function automatic logic [31:0] lanes_to_frame(input logic [7:0] d [4], input logic v [4]);
    logic [31:0] f;
    f = '0;
    for (int k = 0; k < 4; k++) f[31-8*k -: 8] = v[k] ? d[k] : 8'hBC;
    return f;
  endfunction

  task automatic randomize_inputs();
    for (int k = 0; k < 4; k++) begin
      din[k] = 8'($urandom);
      vin[k] = 1'($urandom);
    end
  endtask

  // Advance one clock; the model sees the same inputs the DUT samples at that edge.
  task automatic cycle();
    if (!rst_L) t = -1;
    else begin
      t++;
      if (t % 32 == 0) cur_frame = (t / 32 < TF) ? ALL_COMMA : lanes_to_frame(din, vin);
    end
    @(posedge clk_32f);
    @(negedge clk_32f);
    if (t < 0) begin
      exp_data = 1'b0; exp_fs = 1'b0; exp_ta = 1'b0; exp_load = 1'b0;
    end else begin
      exp_data = cur_frame[31 - (t % 32)];
      exp_fs   = (t % 32 == 0);
      exp_ta   = (t / 32 >= TF);
      exp_load = (t % 32 == 31) && (t / 32 + 1 >= TF);
    end
  endtask

  // Runs 32 cycles, gathering the serial word and stream statistics for the caller to judge.
  task automatic collect32(output logic [31:0] word, output int mism, output logic fs0,
                           output logic ta0, output int load_cnt, output int load_idx);
    word = '0; mism = 0; fs0 = 1'b0; ta0 = 1'b0; load_cnt = 0; load_idx = -1;
    for (int i = 0; i < 32; i++) begin
      cycle();
      word = {word[30:0], data_out};
      if (i == 0) begin
        fs0 = frame_start;
        ta0 = tx_active;
      end
      if (load === 1'b1) begin
        load_cnt++;
        load_idx = i;
      end
      if ({data_out, frame_start, tx_active, load} !== {exp_data, exp_fs, exp_ta, exp_load}) mism++;
    end
  endtask

  task automatic test_reset();
    rst_L = 1'b0;
    randomize_inputs();
    for (int i = 0; i < 3; i++) begin
      cycle();
      total++;
      if ({data_out, load, frame_start, tx_active} !== 4'b0000) begin
        bad++;
        $display("FAIL reset_outputs[%0d]: got %b expected 0000", i,
                 {data_out, load, frame_start, tx_active});
      end
    end
  endtask

  task automatic test_training();
    logic [31:0] w; int m, lc, li; logic fs, ta;
    rst_L = 1'b1;
    collect32(w, m, fs, ta, lc, li);
    total++; if (w !== ALL_COMMA) begin bad++; $display("FAIL train_frame0: got %h expected %h", w, ALL_COMMA); end
    total++; if ({fs, w[31]} !== 2'b11) begin bad++; $display("FAIL train_first_bit: got fs/bit %b expected 11", {fs, w[31]}); end
    total++; if (lc !== 0) begin bad++; $display("FAIL train_early_load: got %0d loads expected 0", lc); end
    total++; if (m !== 0) begin bad++; $display("FAIL train_stream0: got %0d bad cycles expected 0", m); end
    collect32(w, m, fs, ta, lc, li);
    total++; if (w !== ALL_COMMA) begin bad++; $display("FAIL train_frame1: got %h expected %h", w, ALL_COMMA); end
    total++; if (lc !== 1 || li !== 31) begin bad++; $display("FAIL train_load_pos: got cnt=%0d idx=%0d expected cnt=1 idx=31", lc, li); end
    total++; if (ta !== 1'b0) begin bad++; $display("FAIL train_tx_active: got %b expected 0", ta); end
    total++; if (m !== 0) begin bad++; $display("FAIL train_stream1: got %0d bad cycles expected 0", m); end
  endtask

  task automatic test_data();
    logic [31:0] w; int m, lc, li; logic fs, ta;
    for (int i = 0; i < 40 && load !== 1'b1; i++) cycle();
    total++;
    if (load !== 1'b1) begin bad++; $display("FAIL data_wait_load: got %b expected 1 within 40 cycles", load); end
    din = '{8'hA5, 8'h3C, 8'hFF, 8'h01};
    vin = '{1'b1, 1'b1, 1'b1, 1'b1};
    collect32(w, m, fs, ta, lc, li);
    total++; if (w !== 32'hA53CFF01) begin bad++; $display("FAIL data_frame: got %h expected a53cff01", w); end
    total++; if ({fs, ta} !== 2'b11) begin bad++; $display("FAIL data_first_flags: got fs/ta %b expected 11", {fs, ta}); end
    total++; if (m !== 0) begin bad++; $display("FAIL data_stream: got %0d bad cycles expected 0", m); end
  endtask

  task automatic test_invalid_lanes();
    logic [31:0] w; int m, lc, li; logic fs, ta;
    din = '{8'hA5, 8'h3C, 8'hFF, 8'h01};
    vin = '{1'b1, 1'b0, 1'b1, 1'b0};
    collect32(w, m, fs, ta, lc, li);
    total++; if (w !== 32'hA5BCFFBC) begin bad++; $display("FAIL invalid_frame: got %h expected a5bcffbc", w); end
    total++; if (m !== 0) begin bad++; $display("FAIL invalid_stream: got %0d bad cycles expected 0", m); end
    // Valid comma-valued data passes unchanged; an invalid non-zero lane still becomes comma.
    din = '{8'hBC, 8'h77, 8'h00, 8'hBC};
    vin = '{1'b1, 1'b0, 1'b1, 1'b1};
    collect32(w, m, fs, ta, lc, li);
    total++; if (w !== 32'hBCBC00BC) begin bad++; $display("FAIL comma_data_frame: got %h expected bcbc00bc", w); end
  endtask

  task automatic test_back_to_back();
    logic [31:0] w1, w2; int m1, m2, lc1, li1, lc2, li2; logic fs, ta;
    din = '{8'h00, 8'h00, 8'h00, 8'h00};
    vin = '{1'b1, 1'b1, 1'b1, 1'b1};
    collect32(w1, m1, fs, ta, lc1, li1);
    din = '{8'hFF, 8'hFF, 8'hFF, 8'hFF};
    collect32(w2, m2, fs, ta, lc2, li2);
    total++; if (w1 !== 32'h0) begin bad++; $display("FAIL b2b_zeros: got %h expected 00000000", w1); end
    total++; if (w2 !== 32'hFFFFFFFF) begin bad++; $display("FAIL b2b_ones: got %h expected ffffffff", w2); end
    total++; if (lc1 !== 1 || li1 !== 31 || lc2 !== 1 || li2 !== 31) begin
      bad++; $display("FAIL b2b_load_period: got %0d@%0d %0d@%0d expected 1@31 1@31", lc1, li1, lc2, li2);
    end
    total++; if (m1 + m2 !== 0) begin bad++; $display("FAIL b2b_stream: got %0d bad cycles expected 0", m1 + m2); end
  endtask

  task automatic test_toggle();
    logic [7:0]  id [4];
    logic        iv [4];
    logic [31:0] w, e;
    int          m;
    for (int f = 0; f < 4; f++) begin
      for (int k = 0; k < 4; k++) begin
        id[k] = 8'($urandom);
        iv[k] = 1'($urandom_range(0, 3) != 0);
      end
      e = '0;
      for (int k = 0; k < 4; k++) e[31-8*k -: 8] = iv[k] ? id[k] : 8'hBC;
      din = id;
      vin = iv;
      w = '0; m = 0;
      for (int i = 0; i < 32; i++) begin
        cycle();
        w = {w[30:0], data_out};
        if ({data_out, frame_start, tx_active, load} !== {exp_data, exp_fs, exp_ta, exp_load}) m++;
        if (load !== 1'b1) randomize_inputs();
      end
      total++; if (w !== e) begin bad++; $display("FAIL toggle_frame[%0d]: got %h expected %h", f, w, e); end
      total++; if (m !== 0) begin bad++; $display("FAIL toggle_stream[%0d]: got %0d bad cycles expected 0", f, m); end
    end
  endtask

  task automatic test_mid_reset();
    logic [31:0] w, e; int m, lc, li; logic fs, ta;
    randomize_inputs();
    for (int i = 0; i < 13; i++) cycle();
    rst_L = 1'b0;
    cycle();
    total++;
    if ({data_out, load, frame_start, tx_active} !== 4'b0000) begin
      bad++; $display("FAIL midreset_outputs: got %b expected 0000", {data_out, load, frame_start, tx_active});
    end
    rst_L = 1'b1;
    collect32(w, m, fs, ta, lc, li);
    total++; if (w !== ALL_COMMA || {fs, ta} !== 2'b10) begin
      bad++; $display("FAIL midreset_train0: got %h fs/ta %b expected %h 10", w, {fs, ta}, ALL_COMMA);
    end
    collect32(w, m, fs, ta, lc, li);
    total++; if (w !== ALL_COMMA || lc !== 1 || li !== 31) begin
      bad++; $display("FAIL midreset_train1: got %h load %0d@%0d expected %h 1@31", w, lc, li, ALL_COMMA);
    end
    for (int k = 0; k < 4; k++) begin
      din[k] = 8'($urandom);
      vin[k] = 1'b1;
    end
    e = {din[0], din[1], din[2], din[3]};
    collect32(w, m, fs, ta, lc, li);
    total++; if (w !== e || ta !== 1'b1) begin
      bad++; $display("FAIL midreset_resume: got %h ta %b expected %h 1", w, ta, e);
    end
    total++; if (m !== 0) begin bad++; $display("FAIL midreset_stream: got %0d bad cycles expected 0", m); end
  endtask

  initial begin
    randomize_inputs();
    test_reset();
    test_training();
    test_data();
    test_invalid_lanes();
    test_back_to_back();
    test_toggle();
    test_mid_reset();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "simulation time limit reached");
  end

endmodule
